// File: rtl/nios2_debug_jtag_host_seq.sv
// Host-side virtual-JTAG sequencer: plays one UIR/CDR/SDR/UDR scan per command with a divided TCK
// and returns the DR bits captured from the debug slave.
module nios2_debug_jtag_host_seq #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int unsigned CntW = $clog2(DR_WIDTH + 1);
  localparam int unsigned DivW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StUir, StCdr, StSdr, StUdr} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic                phase_q, phase_d;
  logic [CntW-1:0]     bit_q, bit_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic busy, half_end, tck_rise, period_end;

  assign busy       = (state_q != StIdle);
  assign half_end   = (div_q == DivW'(TCK_DIV - 1));
  // phase_q is TCK itself: low half first, so TCK rises when the low half ends.
  assign tck_rise   = busy && !phase_q && half_end;
  assign period_end = busy && phase_q && half_end;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    ir_in_d     = ir_in_q;
    ir_out_d    = ir_out_q;
    rsp_valid_d = 1'b0;

    if (busy) begin
      if (half_end) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StUir;
          tx_d    = cmd_data;
          ir_in_d = cmd_ir;
          rx_d    = '0;
          bit_d   = '0;
          div_d   = '0;
          phase_d = 1'b0;
        end
      end
      StUir: begin
        if (period_end) begin
          ir_out_d = vji_ir_out;
          state_d  = StCdr;
        end
      end
      StCdr: begin
        if (period_end) state_d = StSdr;
      end
      StSdr: begin
        if (tck_rise) begin
          rx_d  = {vji_tdo, rx_q[DR_WIDTH-1:1]};
          bit_d = bit_q + CntW'(1);
        end
        if (period_end) begin
          tx_d = tx_q >> 1;
          if (bit_q == CntW'(DR_WIDTH)) state_d = StUdr;
        end
      end
      StUdr: begin
        if (period_end) begin
          rsp_data_d  = rx_q;
          rsp_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      div_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      ir_in_q     <= ir_in_d;
      ir_out_q    <= ir_out_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign vji_rti    = (state_q == StIdle);
  assign vji_uir    = (state_q == StUir);
  assign vji_cdr    = (state_q == StCdr);
  assign vji_sdr    = (state_q == StSdr);
  assign vji_udr    = (state_q == StUdr);
  assign vji_tck    = phase_q;
  assign vji_tdi    = (state_q == StSdr) && tx_q[0];
  assign vji_ir_in  = ir_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_out = ir_out_q;

endmodule
